eye_tracker_host_if: RTL and testbench

Host command front-end that sits directly upstream of the EyeTracker register block. It turns a byte stream from the UART receiver into one-cycle register write or read strobes: a one-hot write-enable vector with data, or a one-hot read-enable vector. It captures the register block's combinational read data and returns a response byte to the UART transmitter through a valid/ready handshake. It includes an inter-byte timeout, command validation and ACK/NAK responses.

---
 rtl/eye_tracker_pkg.sv | 21 ++
 rtl/eye_tracker_timeout.sv | 35 +++
 rtl/eye_tracker_host_if.sv | 121 ++++++++++++
 tb/tb_eye_tracker_host_if.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eye_tracker_pkg.sv
// Shared definitions for the EyeTracker host command front-end.
// State encoding, command field positions and response bytes.
package eye_tracker_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_DATA = 3'd1,
        WRITE     = 3'd2,
        READ      = 3'd3,
        SEND      = 3'd4
    } host_state_e;

    localparam int CMD_WR_BIT   = 7;
    localparam int CMD_RSVD_MSB = 6;
    localparam int CMD_RSVD_LSB = 2;
    localparam int CMD_ADDR_MSB = 1;

    localparam logic [7:0] ACK = 8'h06;
    localparam logic [7:0] NAK = 8'h15;

endpackage

// File: rtl/eye_tracker_timeout.sv
// Inter-byte timeout counter: clears, counts while enabled and
// flags the cycle in which the count reaches TIMEOUT_CYCLES-1.
module eye_tracker_timeout #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic done
);
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CW-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = en && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/eye_tracker_host_if.sv
// Host byte-stream front-end: decodes UART commands into one-cycle
// register strobes and returns ACK/NAK or read data to the transmitter.
module eye_tracker_host_if
    import eye_tracker_pkg::*;
#(
    parameter int          DATA_WIDTH     = 8,
    parameter int          WE_WIDTH       = 4,
    parameter int          RE_WIDTH       = 4,
    parameter int          TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0]  ACK_BYTE       = ACK,
    parameter logic [7:0]  NAK_BYTE       = NAK
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  iRX_VALID,
    input  logic [DATA_WIDTH-1:0] iRX_DATA,
    output logic                  oTX_VALID,
    output logic [DATA_WIDTH-1:0] oTX_DATA,
    input  logic                  iTX_READY,
    output logic [WE_WIDTH-1:0]   oWE_BIT,
    output logic [RE_WIDTH-1:0]   oRE_BIT,
    output logic [DATA_WIDTH-1:0] oDATA,
    input  logic [DATA_WIDTH-1:0] iRD,
    output logic                  oRX_DROP
);
    host_state_e           state_d, state_q;
    logic [CMD_ADDR_MSB:0] addr_d, addr_q;
    logic [DATA_WIDTH-1:0] data_d, data_q;
    logic [DATA_WIDTH-1:0] tx_d, tx_q;
    logic                  drop_d, drop_q;
    logic                  tmr_clr, tmr_en, tmr_done;

    eye_tracker_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk  (CLK),
        .rst_n(RST_N),
        .clr  (tmr_clr),
        .en   (tmr_en),
        .done (tmr_done)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        tx_d    = tx_q;
        drop_d  = 1'b0;
        tmr_clr = 1'b0;
        tmr_en  = 1'b0;
        unique case (state_q)
            IDLE: begin
                tmr_clr = 1'b1;
                if (iRX_VALID) begin
                    if (iRX_DATA[CMD_RSVD_MSB:CMD_RSVD_LSB] != '0) begin
                        tx_d    = DATA_WIDTH'(NAK_BYTE);
                        state_d = SEND;
                    end else begin
                        addr_d  = iRX_DATA[CMD_ADDR_MSB:0];
                        state_d = iRX_DATA[CMD_WR_BIT] ? WAIT_DATA : READ;
                    end
                end
            end
            WAIT_DATA: begin
                // A byte arriving on the terminal cycle still wins.
                if (iRX_VALID) begin
                    data_d  = iRX_DATA;
                    state_d = WRITE;
                end else begin
                    tmr_en = 1'b1;
                    if (tmr_done) begin
                        tx_d    = DATA_WIDTH'(NAK_BYTE);
                        state_d = SEND;
                    end
                end
            end
            WRITE: begin
                drop_d  = iRX_VALID;
                tx_d    = DATA_WIDTH'(ACK_BYTE);
                state_d = SEND;
            end
            READ: begin
                drop_d  = iRX_VALID;
                tx_d    = iRD;
                state_d = SEND;
            end
            SEND: begin
                drop_d = iRX_VALID;
                if (iTX_READY) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            tx_q    <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            tx_q    <= tx_d;
            drop_q  <= drop_d;
        end
    end

    // Strobes decode straight from state so reset cuts them at once.
    assign oWE_BIT   = (state_q == WRITE) ? (WE_WIDTH'(1) << addr_q) : '0;
    assign oRE_BIT   = (state_q == READ) ? (RE_WIDTH'(1) << addr_q) : '0;
    assign oTX_VALID = (state_q == SEND);
    assign oTX_DATA  = tx_q;
    assign oDATA     = data_q;
    assign oRX_DROP  = drop_q;

endmodule

// File: tb/tb_eye_tracker_host_if.sv
// Scoreboard bench for eye_tracker_host_if with a reference command model
// and an emulated register block behind the strobes.
module tb_eye_tracker_host_if;

    localparam int TO = 16;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic [3:0] we_bit;
    logic [3:0] re_bit;
    logic [7:0] wdata;
    logic [7:0] rd;
    logic       rx_drop;

    eye_tracker_host_if #(
        .DATA_WIDTH    (8),
        .WE_WIDTH      (4),
        .RE_WIDTH      (4),
        .TIMEOUT_CYCLES(TO),
        .ACK_BYTE      (8'h06),
        .NAK_BYTE      (8'h15)
    ) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .iRX_VALID(rx_valid),
        .iRX_DATA (rx_data),
        .oTX_VALID(tx_valid),
        .oTX_DATA (tx_data),
        .iTX_READY(tx_ready),
        .oWE_BIT  (we_bit),
        .oRE_BIT  (re_bit),
        .oDATA    (wdata),
        .iRD      (rd),
        .oRX_DROP (rx_drop)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit         wr;
        logic [1:0] a;
        logic [7:0] d;
    } strb_t;

    strb_t      sq[$];
    logic [7:0] tq[$];
    logic [7:0] ref_mem[4];
    logic [7:0] blk_mem[4];

    int n_chk = 0;
    int n_fail = 0;
    int n_tx = 0;
    int tx_seen = 0;
    int exp_drop = 0;
    int drop_seen = 0;
    bit hold_low = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Emulated register block: writes land on the strobe, reads are combinational.
    always @(posedge CLK) begin
        for (int i = 0; i < 4; i++)
            if (we_bit[i]) blk_mem[i] <= wdata;
    end

    always_comb begin
        rd = 8'h00;
        for (int i = 0; i < 4; i++)
            if (re_bit[i]) rd = blk_mem[i];
    end

    initial begin
        forever begin
            @(posedge CLK);
            #1;
            tx_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        logic       pv, pr;
        logic [7:0] pd;
        strb_t      e;
        logic [7:0] t;
        pv = 1'b0; pr = 1'b0; pd = 8'h00;
        forever begin
            @(negedge CLK);
            if (!RST_N) begin
                pv = 1'b0;
            end else begin
                if (we_bit != 4'b0 || re_bit != 4'b0) begin
                    if (sq.size() == 0) begin
                        chk("unexpected_strobe", {we_bit, re_bit}, 0);
                    end else begin
                        e = sq.pop_front();
                        if (e.wr) begin
                            chk("we_bit", we_bit, 4'b0001 << e.a);
                            chk("we_re_bit", re_bit, 0);
                            chk("wr_data", wdata, e.d);
                        end else begin
                            chk("re_bit", re_bit, 4'b0001 << e.a);
                            chk("re_we_bit", we_bit, 0);
                        end
                    end
                end
                if (tx_valid && pv && !pr)
                    chk("tx_hold", tx_data, pd);
                if (tx_valid && tx_ready) begin
                    if (tq.size() == 0) begin
                        chk("unexpected_tx", tx_data, 0);
                    end else begin
                        t = tq.pop_front();
                        chk("tx_data", tx_data, t);
                    end
                    tx_seen++;
                end
                if (rx_drop) drop_seen++;
                pv = tx_valid; pr = tx_ready; pd = tx_data;
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic wait_resp();
        int c = 0;
        while (tx_seen < n_tx && c < 400) begin
            tick();
            c++;
        end
        if (tx_seen < n_tx)
            chk("resp_timeout", tx_seen, n_tx);
    endtask

    task automatic wait_txv();
        int c = 0;
        while (!tx_valid && c < 50) begin
            tick();
            c++;
        end
        if (!tx_valid) chk("txv_timeout", tx_valid, 1);
    endtask

    task automatic do_write(input logic [1:0] a, input logic [7:0] d,
                            input int gap, input bit extra);
        sq.push_back('{1'b1, a, d});
        tq.push_back(8'h06);
        ref_mem[a] = d;
        n_tx++;
        send_byte({1'b1, 5'b0, a});
        repeat (gap) tick();
        send_byte(d);
        if (extra) begin
            send_byte(8'($urandom));
            exp_drop++;
        end
        wait_resp();
    endtask

    task automatic do_read(input logic [1:0] a);
        sq.push_back('{1'b0, a, 8'h00});
        tq.push_back(ref_mem[a]);
        n_tx++;
        send_byte({6'b0, a});
        wait_resp();
    endtask

    task automatic do_bad(input logic [7:0] b);
        tq.push_back(8'h15);
        n_tx++;
        send_byte(b);
        wait_resp();
    endtask

    task automatic do_timeout(input logic [1:0] a);
        tq.push_back(8'h15);
        n_tx++;
        send_byte({1'b1, 5'b0, a});
        wait_resp();
    endtask

    task automatic do_read_hold(input logic [1:0] a);
        hold_low = 1'b1;
        tx_ready = 1'b0;
        sq.push_back('{1'b0, a, 8'h00});
        tq.push_back(ref_mem[a]);
        n_tx++;
        send_byte({6'b0, a});
        wait_txv();
        chk("hold_data0", tx_data, ref_mem[a]);
        send_byte(8'h01);
        exp_drop++;
        repeat (10) begin
            chk("hold_valid", tx_valid, 1);
            chk("hold_data", tx_data, ref_mem[a]);
            tick();
        end
        hold_low = 1'b0;
        wait_resp();
    endtask

    initial begin
        logic [7:0] b;
        int         r;
        for (int i = 0; i < 4; i++) begin
            ref_mem[i] = 8'h00;
            blk_mem[i] = 8'h00;
        end
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_ready = 1'b0;
        RST_N    = 1'b0;
        #3;
        chk("rst_we", we_bit, 0);
        chk("rst_re", re_bit, 0);
        chk("rst_data", wdata, 0);
        chk("rst_txv", tx_valid, 0);
        chk("rst_txd", tx_data, 0);
        chk("rst_drop", rx_drop, 0);
        repeat (3) tick();
        RST_N = 1'b1;
        tick();

        do_write(2'd2, 8'h5A, 0, 1'b0);
        do_read_hold(2'd2);
        do_bad(8'h44);
        do_timeout(2'd1);
        do_write(2'd1, 8'hC3, TO - 2, 1'b0);
        do_write(2'd1, 8'h3C, TO - 1, 1'b0);
        do_read(2'd1);

        for (int a = 0; a < 4; a++) begin
            do_write(2'(a), 8'($urandom), $urandom_range(0, 3), 1'b0);
            do_read_hold(2'(a));
        end

        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            if (r < 4) begin
                do_write(2'($urandom), 8'($urandom), $urandom_range(0, TO - 1),
                         1'($urandom));
            end else if (r < 7) begin
                do_read(2'($urandom));
            end else if (r == 7) begin
                b = 8'($urandom);
                if (b[6:2] == 5'b0) b[3] = 1'b1;
                do_bad(b);
            end else if (r == 8) begin
                do_timeout(2'($urandom));
            end else begin
                do_read_hold(2'($urandom));
            end
        end

        send_byte(8'h83);
        send_byte(8'hA5);
        #1;
        chk("mid_we_on", we_bit, 4'b1000);
        RST_N = 1'b0;
        #1;
        chk("mid_we_cut", we_bit, 0);
        chk("mid_txv", tx_valid, 0);
        chk("mid_txd", tx_data, 0);
        tick();
        RST_N = 1'b1;
        repeat (4) begin
            tick();
            chk("post_rst_txv", tx_valid, 0);
        end
        chk("post_rst_tq", tq.size(), 0);
        do_read(2'd3);
        do_write(2'd3, 8'h77, 1, 1'b0);
        do_read(2'd3);

        repeat (3) tick();
        chk("drop_count", drop_seen, exp_drop);
        chk("strobe_q_empty", sq.size(), 0);
        chk("tx_q_empty", tq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
